// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int QUARTER_UNITS = 1;
  localparam int DOLLAR_UNITS  = 4;

endpackage

// File: rtl/credit_onehot_reg.sv
// One-hot credit level register; resets to "credit == 0" (bit 0 set).
module credit_onehot_reg #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_oh_nxt,
  output logic [W-1:0] o_oh
);

  logic [W-1:0] r_oh;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_oh <= {{(W-1){1'b0}}, 1'b1};
    else          r_oh <= i_oh_nxt;
  end

  assign o_oh = r_oh;

endmodule

// File: rtl/vend_credit_fsm.sv
// Coin-credit vending controller: accumulates quarters/dollars, vends at price,
// then pays out pending change one quarter per cycle. All outputs registered.
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter  int PRICE_UNITS = 6,
  localparam int MAX_UNITS   = PRICE_UNITS + 3,
  localparam int CW          = $clog2(MAX_UNITS + 1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               coin_q,
  input  logic               coin_d,
  input  logic               cancel,
  input  logic               dispense_ack,
  output logic [CW-1:0]      credit,
  output logic [MAX_UNITS:0] credit_oh,
  output logic               dispense,
  output logic               change_q,
  output logic               coin_reject,
  output logic               busy
);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_credit, w_credit_nxt, w_sum, w_coin_val;
  logic               r_dispense, w_dispense_nxt;
  logic               r_change_q, w_change_nxt;
  logic               r_reject, w_reject_nxt;
  logic               r_busy;
  logic               w_any_coin;
  logic [MAX_UNITS:0] w_oh_nxt;

  assign w_any_coin = coin_q | coin_d;
  // A dollar wins over a simultaneous quarter; the quarter is bounced.
  assign w_coin_val = coin_d ? CW'(DOLLAR_UNITS) :
                      coin_q ? CW'(QUARTER_UNITS) : '0;
  assign w_sum      = r_credit + w_coin_val;

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_dispense_nxt = r_dispense;
    w_change_nxt   = 1'b0;
    w_reject_nxt   = 1'b0;
    case (r_state)
      ACCUM: begin
        if (cancel && r_credit != '0) begin
          w_state_nxt  = CHANGE;
          w_reject_nxt = w_any_coin;
        end else if (w_any_coin) begin
          w_reject_nxt = coin_q & coin_d;
          if (w_sum >= CW'(PRICE_UNITS)) begin
            w_credit_nxt   = w_sum - CW'(PRICE_UNITS);
            w_dispense_nxt = 1'b1;
            w_state_nxt    = VEND;
          end else begin
            w_credit_nxt = w_sum;
          end
        end
      end
      VEND: begin
        w_reject_nxt = w_any_coin;
        if (dispense_ack) begin
          w_dispense_nxt = 1'b0;
          w_state_nxt    = (r_credit != '0) ? CHANGE : ACCUM;
        end
      end
      CHANGE: begin
        w_reject_nxt = w_any_coin;
        // Leave on the last pulse so busy drops together with credit reaching 0.
        if (r_credit != '0) begin
          w_change_nxt = 1'b1;
          w_credit_nxt = r_credit - 1'b1;
          if (r_credit == CW'(1)) w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt    = ACCUM;
        w_credit_nxt   = '0;
        w_dispense_nxt = 1'b0;
      end
    endcase
    w_oh_nxt = {{MAX_UNITS{1'b0}}, 1'b1} << w_credit_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ACCUM;
      r_credit   <= '0;
      r_dispense <= 1'b0;
      r_change_q <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_dispense <= w_dispense_nxt;
      r_change_q <= w_change_nxt;
      r_reject   <= w_reject_nxt;
      r_busy     <= (w_state_nxt != ACCUM);
    end
  end

  credit_onehot_reg #(.W(MAX_UNITS + 1)) u_oh (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_oh_nxt (w_oh_nxt),
    .o_oh     (credit_oh)
  );

  assign credit      = r_credit;
  assign dispense    = r_dispense;
  assign change_q    = r_change_q;
  assign coin_reject = r_reject;
  assign busy        = r_busy;

endmodule

// File: doc/vend_credit_fsm.md
VEND_CREDIT_FSM -- requirements
Module: vend_credit_fsm

Interface
REQ-001 Parameter PRICE_UNITS, default 6, SHALL be the item price in quarter units (6 = $1.50); legal range 1..60.
REQ-002 Localparam MAX_UNITS SHALL equal PRICE_UNITS+3, the highest credit reachable in one step.
REQ-003 Localparam CW SHALL equal $clog2(MAX_UNITS+1), the credit counter width.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 coin_q  input  1  one-cycle pulse: quarter inserted (+1 unit).
REQ-007 coin_d  input  1  one-cycle pulse: dollar inserted (+4 units).
REQ-008 cancel  input  1  one-cycle pulse: refund request.
REQ-009 dispense_ack  input  1  level: mechanism has released the item.
REQ-010 credit  output  CW  current credit in quarter units.
REQ-011 credit_oh  output  MAX_UNITS+1  one-hot credit level; bit k high iff credit==k.
REQ-012 dispense  output  1  level: item release requested.
REQ-013 change_q  output  1  one-cycle pulse: eject one quarter.
REQ-014 coin_reject  output  1  one-cycle pulse: inserted coin returned unaccepted.
REQ-015 busy  output  1  high in VEND or CHANGE.

Function
REQ-016 The FSM SHALL have three states: ACCUM, VEND, CHANGE.
REQ-017 All outputs SHALL be registered; every response appears the cycle after the causing input.
REQ-018 ACCUM, single coin, sum=credit+value < PRICE_UNITS: credit <= sum; state stays ACCUM.
REQ-019 ACCUM, single coin, sum >= PRICE_UNITS: credit <= sum-PRICE_UNITS (pending change), dispense <= 1, state -> VEND.
REQ-020 coin_q and coin_d in same cycle in ACCUM: dollar accepted per REQ-018/019, quarter rejected (coin_reject pulse).
REQ-021 cancel in ACCUM with credit>0: state -> CHANGE, any same-cycle coin rejected; with credit==0: no effect, same-cycle coin accepted normally.
REQ-022 VEND: dispense held high until dispense_ack sampled high; then dispense <= 0 and state -> CHANGE if credit>0, else ACCUM.
REQ-023 CHANGE: change_q pulses once per cycle while credit>0, credit decrements by 1 with each pulse; when credit reaches 0, state -> ACCUM, change_q low.
REQ-024 Any coin in VEND or CHANGE SHALL be rejected (coin_reject pulse), credit unchanged; two coins same cycle produce one coin_reject pulse.
REQ-025 cancel in VEND or CHANGE SHALL be ignored.
REQ-026 credit SHALL never exceed MAX_UNITS and never wrap below 0.
REQ-027 credit_oh SHALL be exactly one-hot at all times after reset.
REQ-028 busy SHALL equal (state != ACCUM), registered.

Reset
REQ-029 RST_N low at a rising edge SHALL force state ACCUM, credit 0, credit_oh bit0 only, dispense/change_q/coin_reject/busy 0.
REQ-030 Reset mid-VEND or mid-CHANGE SHALL discard pending credit with no further change_q pulses; inputs during reset ignored.

Structure
REQ-031 Package vend_pkg SHALL hold the state enum (ACCUM, VEND, CHANGE) and coin value constants QUARTER_UNITS=1, DOLLAR_UNITS=4.
REQ-032 One sub-module credit_onehot_reg SHALL hold the MAX_UNITS+1 one-hot credit flops with synchronous active-low reset to bit0; the FSM drives its next-state vector.

Verification
REQ-033 Reset, then six coin_q pulses, ack one cycle after dispense -> dispense rises after 6th coin, no change_q, credit returns 0, ACCUM.
REQ-034 credit=5, coin_d -> dispense, credit=3; after ack exactly 3 change_q pulses on consecutive cycles, then credit 0.
REQ-035 credit=2, coin_q and coin_d same cycle -> credit 6 path: VEND, pending credit 0, one coin_reject pulse.
REQ-036 credit=3, cancel with coin_q same cycle -> coin_reject, 3 change_q pulses, credit 0; cancel at credit 0 -> no activity.
REQ-037 In VEND, coin_d and cancel pulses -> coin_reject each, cancel ignored, dispense stays high until ack.
REQ-038 RST_N low during CHANGE with credit=2 -> next cycle all outputs at reset values, no further change_q; credit_oh checked one-hot every cycle.
